// File: rtl/axi_frame_packer_if.sv
//------------------------------------------------------------------------------
// Module      : axi_if
// Description : AXI-Stream bundle (tdata/tvalid/tready/tlast/tuser) with
//               master and slave modports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/axi_frame_packer.sv
//------------------------------------------------------------------------------
// Module      : axi_frame_packer
// Description : Wraps each input AXI-Stream packet into header/payload/trailer
//               frames; optional trailer checksum under FRAME_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_frame_packer #(
    parameter int         DATA_W    = 32,
    parameter int         USER_W    = 8,
    parameter int         MAX_BEATS = 256,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input  logic  clk,
    input  logic  rst_n,
    axi_if.slave  s_axi_if,
    axi_if.master m_axi_if
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("axi_frame_packer: DATA_W must be 32");
        end
        if (USER_W < 3 || USER_W > 8) begin : g_bad_user_w
            $error("axi_frame_packer: USER_W must be in 3..8");
        end
        if (MAX_BEATS < 1 || MAX_BEATS > 65535) begin : g_bad_max_beats
            $error("axi_frame_packer: MAX_BEATS must be in 1..65535");
        end
    endgenerate

    localparam logic [15:0] c_max_beats = 16'(MAX_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_TRL  = 2'd2
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [31:0]       r_tdata,  w_tdata_nxt;
    logic [USER_W-1:0] r_tuser,  w_tuser_nxt;
    logic              r_tlast,  w_tlast_nxt;
    logic              r_tvalid, w_tvalid_nxt;
    logic [15:0]       r_seq,    w_seq_nxt;
    logic [15:0]       r_count,  w_count_nxt;
    logic              r_trunc,  w_trunc_nxt;

    logic              w_out_free;
    logic              w_s_tready;
    logic              w_accept;
    logic              w_hdr_load;
    logic [7:0]        w_chan;
    logic [15:0]       w_count_inc;
    logic [15:0]       w_csum;

    assign w_out_free  = !r_tvalid || m_axi_if.tready;
    assign w_s_tready  = (r_state == ST_PAY) && w_out_free;
    assign w_accept    = w_s_tready && s_axi_if.tvalid;
    assign w_hdr_load  = (r_state == ST_IDLE) && s_axi_if.tvalid && w_out_free;
    assign w_chan      = 8'(s_axi_if.tuser);
    assign w_count_inc = r_count + 16'd1;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 16'h0000;
        end else if (w_hdr_load) begin
            r_csum <= 16'h0000;
        end else if (w_accept) begin
            r_csum <= r_csum + s_axi_if.tdata[31:16] + s_axi_if.tdata[15:0];
        end
    end

    assign w_csum = r_csum;
`else
    assign w_csum = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_seq    <= 16'h0000;
            r_count  <= 16'h0000;
            r_trunc  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tuser  <= w_tuser_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_seq    <= w_seq_nxt;
            r_count  <= w_count_nxt;
            r_trunc  <= w_trunc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tdata_nxt  = r_tdata;
        w_tuser_nxt  = r_tuser;
        w_tlast_nxt  = r_tlast;
        // A free register with nothing new to load goes empty
        w_tvalid_nxt = w_out_free ? 1'b0 : r_tvalid;
        w_seq_nxt    = r_seq;
        w_count_nxt  = r_count;
        w_trunc_nxt  = r_trunc;

        case (r_state)
            ST_IDLE: begin
                // The first data beat stays on the input; only its tuser is read
                if (w_hdr_load) begin
                    w_tdata_nxt  = {SYNC, w_chan, r_seq};
                    w_tuser_nxt  = '0;
                    w_tlast_nxt  = 1'b0;
                    w_tvalid_nxt = 1'b1;
                    w_count_nxt  = 16'h0000;
                    w_state_nxt  = ST_PAY;
                end
            end
            ST_PAY: begin
                if (w_accept) begin
                    w_tdata_nxt  = s_axi_if.tdata;
                    w_tuser_nxt  = '0;
                    w_tuser_nxt[1:0] = 2'b01;
                    w_tlast_nxt  = 1'b0;
                    w_tvalid_nxt = 1'b1;
                    w_count_nxt  = w_count_inc;
                    if (s_axi_if.tlast) begin
                        w_trunc_nxt = 1'b0;
                        w_state_nxt = ST_TRL;
                    end else if (w_count_inc == c_max_beats) begin
                        w_trunc_nxt = 1'b1;
                        w_state_nxt = ST_TRL;
                    end
                end
            end
            ST_TRL: begin
                if (w_out_free) begin
                    w_tdata_nxt  = {r_count, w_csum};
                    w_tuser_nxt  = '0;
                    w_tuser_nxt[2:0] = {r_trunc, 2'b10};
                    w_tlast_nxt  = 1'b1;
                    w_tvalid_nxt = 1'b1;
                    w_seq_nxt    = r_seq + 16'd1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_axi_if.tready = w_s_tready;
    assign m_axi_if.tdata  = r_tdata;
    assign m_axi_if.tuser  = r_tuser;
    assign m_axi_if.tlast  = r_tlast;
    assign m_axi_if.tvalid = r_tvalid;

endmodule

`default_nettype wire

// File: tb/tb_axi_frame_packer.sv
//------------------------------------------------------------------------------
// Module      : tb_axi_frame_packer
// Description : Directed bench for axi_frame_packer (MAX_BEATS=4); trailer
//               checksum expectations follow FRAME_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_frame_packer;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int MB = 4;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  u;
        logic        l;
        int          c;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    mode   = 0;   // m_tready: 0 high, 1 low, 2 random
    int    base;
    beat_t cap[$];
    beat_t ex[$];
    logic        mon_stalled = 1'b0;
    logic [40:0] mon_held    = '0;

    axi_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    axi_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    axi_frame_packer #(
        .DATA_W    (DW),
        .USER_W    (UW),
        .MAX_BEATS (MB),
        .SYNC      (8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_axi_if (s_if),
        .m_axi_if (m_if)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'b0;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [15:0] cs(input logic [15:0] v);
`ifdef FRAME_CHECKSUM_EN
        return v;
`else
        return v & 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [31:0] d,
                            input logic [7:0] u, input logic l);
        beat_t b;
        b = '{d: 32'h0, u: 8'h0, l: 1'b0, c: 0};
        if (i < cap.size()) b = cap[i];
        chk(tag, 64'({b.l, b.u, b.d}), 64'({l, u, d}));
    endtask

    // Output monitor: captures handshakes and checks hold-while-stalled
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mon_stalled = 1'b0;
        end else begin
            if (mon_stalled) begin
                checks++;
                assert (m_if.tvalid === 1'b1 && {m_if.tlast, m_if.tuser, m_if.tdata} === mon_held) else begin
                    errors++;
                    $error("FAIL hold_stable observed=%b/%h expected=1/%h", m_if.tvalid,
                           {m_if.tlast, m_if.tuser, m_if.tdata}, mon_held);
                end
            end
            if (m_if.tvalid && m_if.tready)
                cap.push_back('{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast, c: cyc});
            mon_stalled = m_if.tvalid && !m_if.tready;
            mon_held    = {m_if.tlast, m_if.tuser, m_if.tdata};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was taken
    task automatic send_beat(input logic [31:0] d, input logic [7:0] u, input logic l);
        int t;
        t = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!s_if.tready && t < 300);
        if (!s_if.tready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=no_tready expected=tready");
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (cap.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (cap.size() < n) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout observed=%0d expected=%0d", cap.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        chk("rst_m_tuser",  64'(m_if.tuser),  64'd0);
        chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-beat packet, seq 0, contiguous N+2 output cycles
        base = cap.size();
        send_beat(32'h00010002, 8'h03, 1'b0);
        send_beat(32'h00030004, 8'h03, 1'b1);
        wait_beats(base + 4);
        chk_beat("t1_hdr", base + 0, 32'hA5030000, 8'h00, 1'b0);
        chk_beat("t1_p0",  base + 1, 32'h00010002, 8'h01, 1'b0);
        chk_beat("t1_p1",  base + 2, 32'h00030004, 8'h01, 1'b0);
        chk_beat("t1_trl", base + 3, {16'h0002, cs(16'h000A)}, 8'h02, 1'b1);
        chk("t1_span", 64'(cap[base + 3].c - cap[base].c), 64'd3);

        // Six beats with MAX_BEATS=4: truncated frame then continuation frame
        base = cap.size();
        for (int i = 1; i <= 6; i++) send_beat(32'(i), 8'h05, i == 6);
        wait_beats(base + 10);
        chk_beat("t2_hdr1", base + 0, 32'hA5050001, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) chk_beat("t2_pay1", base + i, 32'(i), 8'h01, 1'b0);
        chk_beat("t2_trl1", base + 5, {16'h0004, cs(16'h000A)}, 8'h06, 1'b1);
        chk_beat("t2_hdr2", base + 6, 32'hA5050002, 8'h00, 1'b0);
        chk_beat("t2_p5",   base + 7, 32'h00000005, 8'h01, 1'b0);
        chk_beat("t2_p6",   base + 8, 32'h00000006, 8'h01, 1'b0);
        chk_beat("t2_trl2", base + 9, {16'h0002, cs(16'h000B)}, 8'h02, 1'b1);
        chk("t2_no_bubble", 64'(cap[base + 9].c - cap[base].c), 64'd9);

        // Exactly MAX_BEATS with tlast on the last: trunc stays 0
        base = cap.size();
        for (int i = 1; i <= 4; i++) send_beat(32'(i * 16), 8'h07, i == 4);
        wait_beats(base + 6);
        chk_beat("t3_hdr", base + 0, 32'hA5070003, 8'h00, 1'b0);
        chk_beat("t3_p3",  base + 4, 32'h00000040, 8'h01, 1'b0);
        chk_beat("t3_trl", base + 5, {16'h0004, cs(16'h00A0)}, 8'h02, 1'b1);

        // Header held under backpressure for 20 cycles
        mode = 1;
        repeat (2) @(posedge clk);
        #1;
        base = cap.size();
        s_if.tdata  = 32'h12345678;
        s_if.tuser  = 8'h02;
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        chk("t4_hdr_latency", 64'(m_if.tvalid), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_stall", 64'({m_if.tvalid, s_if.tready, m_if.tlast, m_if.tuser, m_if.tdata}),
                64'({1'b1, 1'b0, 1'b0, 8'h00, 32'hA5020004}));
        end
        @(posedge clk);
        #1;
        mode = 0;
        send_beat(32'h12345678, 8'h02, 1'b1);
        wait_beats(base + 3);
        repeat (3) @(posedge clk);
        chk("t4_count", 64'(cap.size()), 64'(base + 3));
        chk_beat("t4_hdr", base + 0, 32'hA5020004, 8'h00, 1'b0);
        chk_beat("t4_pay", base + 1, 32'h12345678, 8'h01, 1'b0);
        chk_beat("t4_trl", base + 2, {16'h0001, cs(16'h68AC)}, 8'h02, 1'b1);
        #1;

        // Random backpressure, ten short packets, seq 5..14
        mode = 2;
        base = cap.size();
        ex.delete();
        for (int p = 0; p < 10; p++) begin
            int          len;
            logic [15:0] sum;
            logic [31:0] d;
            len = int'($urandom_range(1, 3));
            sum = 16'h0000;
            ex.push_back('{d: {8'hA5, 8'(p + 16), 16'(p + 5)}, u: 8'h00, l: 1'b0, c: 0});
            for (int b = 0; b < len; b++) begin
                d   = $urandom;
                sum = sum + d[31:16] + d[15:0];
                ex.push_back('{d: d, u: 8'h01, l: 1'b0, c: 0});
                send_beat(d, 8'(p + 16), b == len - 1);
            end
            ex.push_back('{d: {16'(len), cs(sum)}, u: 8'h02, l: 1'b1, c: 0});
        end
        wait_beats(base + ex.size());
        mode = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_count", 64'(cap.size() - base), 64'(ex.size()));
        foreach (ex[i]) chk_beat("t5_beat", base + i, ex[i].d, ex[i].u, ex[i].l);

        // Reset mid-frame: asynchronous drop, seq and count restart
        send_beat(32'h00000100, 8'h09, 1'b0);
        send_beat(32'h00000200, 8'h09, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 64'(m_if.tvalid), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_in_reset", 64'({m_if.tvalid, s_if.tready}), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = cap.size();
        send_beat(32'h00050006, 8'h01, 1'b1);
        wait_beats(base + 3);
        chk_beat("t6_hdr", base + 0, 32'hA5010000, 8'h00, 1'b0);
        chk_beat("t6_pay", base + 1, 32'h00050006, 8'h01, 1'b0);
        chk_beat("t6_trl", base + 2, {16'h0001, cs(16'h000B)}, 8'h02, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_frame_packer.md
# axi_frame_packer

Framing stage directly downstream of the acquisition FIFO. It consumes the FIFO's AXI-Stream output (one packet per `tlast`) and emits self-describing frames: header beat, payload beats, trailer beat. The header carries sync, channel and sequence number; the trailer carries beat count, truncation status and an optional checksum. Output is fully registered and feeds the link/transport layer.

## Interface
- `DATA_W`, 32, stream data width; only 32 is supported, elaboration error otherwise.
- `USER_W`, 8, `tuser` width; must be ≥3 and ≤8.
- `MAX_BEATS`, 256, maximum payload beats per frame; range 1..65535.
- `SYNC`, 8'hA5, header sync byte.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_axi_if` axi_if.slave: `tdata`[DATA_W], `tvalid`, `tready`, `tlast`, `tuser`[USER_W]; input packets from the FIFO.
- `m_axi_if` axi_if.master: same signal set; framed output.

## Operation
- FSM states: IDLE, PAY, TRL.
- Output register: `m_tdata`, `m_tuser`, `m_tlast` and `m_tvalid` are registered. The output register is free when `!m_tvalid || m_tready`.
- IDLE: `s_tready`=0. When `s_tvalid` and the output register is free:
  - load header `{SYNC, chan, seq}`, where `chan` = `s_tuser` of the first beat, zero-extended to 8 bits;
  - set `m_tuser`=2'b00 (header type), `m_tlast`=0;
  - clear count and checksum, latch `chan`, go to PAY.
  - The first beat is not consumed in IDLE.
- PAY: `s_tready` = output register free.
  - On accept: load `s_tdata` with `m_tuser`=2'b01 and `m_tlast`=0.
  - count += 1; csum += `s_tdata`[31:16] + `s_tdata`[15:0], modulo 2^16.
  - If `s_tlast`, go to TRL with trunc=0.
  - Else if count+1 == MAX_BEATS, go to TRL with trunc=1. The remaining input beats start a new frame.
- TRL: `s_tready`=0. When the output register is free:
  - load trailer `{count[15:0], csum}` with `m_tuser`={.., trunc, 2'b10} (bit 2 = trunc) and `m_tlast`=1;
  - seq += 1, wrapping 16'hFFFF→0; go to IDLE.
- Unused `m_tuser` bits are always 0.
- Output beats carry no input `tuser`; the channel appears only in the header.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_tuser`=0, `s_tready`=0, state=IDLE, seq=0, count=0, csum=0.
- Reset asserted mid-frame: `m_tvalid` drops immediately (asynchronous). The partial frame is discarded, and the next frame uses seq=0.
- Latency: the header appears 1 cycle after the first `s_tvalid` in IDLE. Each accepted payload beat appears on `m_axi_if` the next cycle.
- `m_tdata`, `m_tuser` and `m_tlast` are held stable while `m_tvalid && !m_tready`.
- `m_tvalid` is never dropped without a handshake.
- Throughput with `m_tready`=1: an N-beat packet occupies N+2 consecutive output cycles. Back-to-back frames have no bubbles; the IDLE header load follows the trailer cycle directly.
- A packet of 1 beat yields 3 output beats.
- A packet of exactly MAX_BEATS with `tlast` on the last beat: trunc=0, because `tlast` takes priority.
- Backpressure on `m_tready` propagates combinationally to `s_tready` in PAY; there is no internal skid buffer.

## Configuration
- `FRAME_CHECKSUM_EN` defined: csum accumulator present; trailer[15:0] = checksum as specified.
- Not defined: no accumulator logic; trailer[15:0] = 16'h0000. All other behaviour is identical.

## Test plan
- Reset, then one 2-beat packet `tuser`=8'h03, data 32'h00010002, 32'h00030004 (`tlast`), `m_tready`=1 → 32'hA5030000 (`tuser`=0), 32'h00010002, 32'h00030004 (`tuser`=1), 32'h0002000A (`tuser`=2, `tlast`=1); with the macro off, trailer = 32'h00020000.
- MAX_BEATS=4, 6-beat packet with `tlast` on beat 6 → frame 1: 4 payload beats, trailer count=4, `tuser`=3'b110; frame 2: header seq=1, 2 payload beats, trailer count=2, trunc=0.
- Random `m_tready` (50%) over 100 packets of random length 1..20 → outputs stable while stalled, no lost or duplicated beats, seq 0..99 in order.
- Preload seq by sending 65536 one-beat packets → header of packet 65537 carries seq=16'h0000.
- `rst_n` pulsed low during the payload of a 10-beat packet → `m_tvalid`=0 during reset; the next packet's header has seq=0 and the trailer count covers only the new packet.
- `m_tready`=0 held while a packet waits → exactly one header beat is presented, `s_tready`=0, and the beat is held unchanged for 20 cycles until `m_tready` rises.
